ppu_oam_dma_fsm: RTL and testbench
==================================

# ppu_oam_dma_fsm

OAM DMA engine: the writer side of sprite RAM (SPRAM). On a CPU write to $4014 it copies one 256-byte page of CPU memory into SPRAM, starting at the current OAMADDR offset, while holding the CPU halted. The SPRAM write port it drives is the port the sprite load FSM's reads depend on. Cycle count matches NES DMA: 513 halted cycles, or 514 if started on an odd cycle.

## Interface
- No parameters.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- dma_start  in  1  one-cycle strobe, CPU write to $4014
- dma_page  in  8  source page (high address byte); sampled with dma_start
- oam_addr  in  8  current OAMADDR; sampled with dma_start
- cpu_mem_addr  out  16  CPU memory read address, registered
- cpu_mem_data  in  8  CPU memory read data, valid the cycle after cpu_mem_addr is presented
- spram_write_addr  out  8  SPRAM write address
- spram_write_data  out  8  SPRAM write data
- spram_write_en  out  1  SPRAM write enable
- dma_busy  out  1  transfer in progress; also the CPU halt request
- dma_done  out  1  one-cycle pulse at transfer completion

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE, DONE.
- Cycle parity register `par` toggles every clock and resets to 0.
- IDLE:
  - On dma_start, latch page := dma_page, base := oam_addr, idx := 0, then go to HALT.
  - dma_start is ignored in every state other than IDLE.
- HALT: one dummy cycle. Go to ALIGN if par==1 during this cycle, else go to READ.
- ALIGN: one extra cycle, then READ.
- READ:
  - cpu_mem_addr = {page, idx}, valid throughout this cycle.
  - Next state is WRITE.
- WRITE:
  - spram_write_en=1, spram_write_addr=(base+idx) mod 256, spram_write_data=cpu_mem_data (combinational pass-through).
  - idx increments.
  - If idx was 255, go to DONE; else go to READ.
- DONE:
  - dma_done=1, dma_busy=0.
  - Next state is IDLE.
  - A dma_start in this cycle is ignored.
- dma_busy=1 in HALT, ALIGN, READ and WRITE; 0 in IDLE and DONE.
- spram_write_en=1 only in WRITE.
- Address arithmetic is 8-bit: the destination wraps past 0xFF to 0x00, and the source never leaves the latched page.
- Reset values:
  - State IDLE, par 0, idx 0.
  - cpu_mem_addr 0x0000, spram_write_addr 0x00, spram_write_data 0x00.
  - spram_write_en 0, dma_busy 0, dma_done 0.
- Outside WRITE, spram_write_addr and spram_write_data hold their last values. Only spram_write_en is meaningful.
- cpu_mem_addr holds its last value outside READ.

## Timing
- dma_start sampled at edge E0; dma_busy rises in the cycle after E0 (HALT).
- Even start (par==0 in HALT): HALT + 256×(READ, WRITE) = 513 busy cycles.
- Odd start: HALT + ALIGN + 512 = 514 busy cycles.
- dma_done pulses in the single cycle immediately after the last WRITE. dma_busy is already 0 in that cycle.
- Per byte:
  - Read address presented in cycle n.
  - Data is written into SPRAM at the end of cycle n+1.
  - Bytes are exactly 2 cycles apart.
- Reset mid-transfer:
  - Next cycle: IDLE, dma_busy=0, spram_write_en=0, no dma_done.
  - Bytes already written stay in SPRAM.
- dma_start coincident with rst: reset wins, no transfer.
- Back-to-back transfers: a new dma_start is accepted in the first IDLE cycle after DONE.

## Test plan
- **Basic even-parity transfer.** Preload CPU RAM 0x0200–0x02FF with byte i = i^0xA5. Set oam_addr=0x00, dma_page=0x02, and start with par==0.
  - dma_busy high for exactly 513 cycles.
  - Exactly 256 spram_write_en pulses.
  - SPRAM[i]=i^0xA5 for all i.
  - Exactly one dma_done pulse.
- **Odd-parity start.** Same data, start when par==1 in HALT: dma_busy high for 514 cycles; same SPRAM contents.
- **Destination wrap.** oam_addr=0xFC, page 0x02:
  - CPU 0x0200 lands at SPRAM 0xFC; CPU 0x0204 lands at 0x00; CPU 0x02FF lands at 0xFB.
  - No write outside 0x00–0xFF.
- **Start while busy.** Pulse dma_start with dma_page=0x03 at byte 50 of a page-0x02 transfer.
  - Transfer continues unaffected; all SPRAM data comes from page 0x02.
  - Exactly one dma_done.
- **Reset mid-transfer.** Assert rst after byte 100 is written.
  - Next cycle: dma_busy=0, spram_write_en=0; no dma_done.
  - SPRAM 0x00–0x63 updated, 0x64–0xFF unchanged.
  - A subsequent dma_start completes normally in 513/514 cycles.
- **Integration with ppu_sprite_load_fsm.** DMA a page holding 8 sprites: Y=0, tiles 0x00–0x07, attr 0x1F, X=0x00,0x08,…,0x38. Then pulse sprite_start with curr_row=5 and curr_col=9.
  - Sprite FSM reports sprite_0/1 tile numbers, attributes 0x1F and columns matching the table.
  - sprite_overflow=0.

Source files
------------

// File: rtl/ppu_oam_dma_fsm_if.sv
// OAM DMA bus bundle: CPU start strobe, CPU memory read port, SPRAM write port, status.
// master = DMA engine, slave = the CPU/memory/SPRAM side.
interface ppu_oam_dma_fsm_if;
    logic        dma_start;
    logic [7:0]  dma_page;
    logic [7:0]  oam_addr;
    logic [15:0] cpu_mem_addr;
    logic [7:0]  cpu_mem_data;
    logic [7:0]  spram_write_addr;
    logic [7:0]  spram_write_data;
    logic        spram_write_en;
    logic        dma_busy;
    logic        dma_done;

    modport master (
        input  dma_start, dma_page, oam_addr, cpu_mem_data,
        output cpu_mem_addr, spram_write_addr, spram_write_data,
        output spram_write_en, dma_busy, dma_done
    );

    modport slave (
        output dma_start, dma_page, oam_addr, cpu_mem_data,
        input  cpu_mem_addr, spram_write_addr, spram_write_data,
        input  spram_write_en, dma_busy, dma_done
    );
endinterface

// File: rtl/ppu_oam_dma_fsm.sv
// OAM DMA: copies a 256-byte CPU page into SPRAM at OAMADDR, 513/514 halted cycles.
// One byte per READ/WRITE pair; no backpressure, dma_start ignored unless idle.
module ppu_oam_dma_fsm (
    input  logic                  clk,
    input  logic                  rst,
    ppu_oam_dma_fsm_if.master     bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE, S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic        par_q;
    logic [7:0]  page_q, page_d;
    logic [7:0]  base_q, base_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] rd_addr_q, rd_addr_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_dat_q, wr_dat_d;

    logic [7:0]  idx_inc;
    logic [7:0]  dst_addr;
    logic        busy, done, wr_en;
    logic [7:0]  wr_addr_out, wr_dat_out;

    assign idx_inc  = idx_q + 8'd1;
    assign dst_addr = base_q + idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            par_q     <= 1'b0;
            page_q    <= 8'h00;
            base_q    <= 8'h00;
            idx_q     <= 8'h00;
            rd_addr_q <= 16'h0000;
            wr_addr_q <= 8'h00;
            wr_dat_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            par_q     <= ~par_q;
            page_q    <= page_d;
            base_q    <= base_d;
            idx_q     <= idx_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_dat_q  <= wr_dat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        page_d      = page_q;
        base_d      = base_q;
        idx_d       = idx_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        wr_dat_d    = wr_dat_q;
        busy        = 1'b0;
        done        = 1'b0;
        wr_en       = 1'b0;
        wr_addr_out = wr_addr_q;
        wr_dat_out  = wr_dat_q;

        case (state_q)
            S_IDLE: begin
                if (bus.dma_start) begin
                    page_d  = bus.dma_page;
                    base_d  = bus.oam_addr;
                    idx_d   = 8'h00;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                busy = 1'b1;
                // Odd-cycle starts burn one extra cycle to align reads to even cycles.
                if (par_q) begin
                    state_d = S_ALIGN;
                end else begin
                    state_d   = S_READ;
                    rd_addr_d = {page_q, idx_q};
                end
            end
            S_ALIGN: begin
                busy      = 1'b1;
                state_d   = S_READ;
                rd_addr_d = {page_q, idx_q};
            end
            S_READ: begin
                busy    = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                busy        = 1'b1;
                wr_en       = 1'b1;
                wr_addr_out = dst_addr;
                wr_dat_out  = bus.cpu_mem_data;
                wr_addr_d   = dst_addr;
                wr_dat_d    = bus.cpu_mem_data;
                idx_d       = idx_inc;
                if (idx_q == 8'hFF) begin
                    state_d = S_DONE;
                end else begin
                    state_d   = S_READ;
                    rd_addr_d = {page_q, idx_inc};
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cpu_mem_addr     = rd_addr_q;
    assign bus.spram_write_addr = wr_addr_out;
    assign bus.spram_write_data = wr_dat_out;
    assign bus.spram_write_en   = wr_en;
    assign bus.dma_busy         = busy;
    assign bus.dma_done         = done;
endmodule

// File: tb/tb_ppu_oam_dma_fsm.sv
// Randomized bench for ppu_oam_dma_fsm against a transfer-level reference model.
module tb_ppu_oam_dma_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    ppu_oam_dma_fsm_if bus ();

    ppu_oam_dma_fsm dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [65536];
    logic [7:0] spram [256];
    logic [7:0] spram_snap [256];

    int   cyc = 0;
    logic par_m = 1'b0;
    int   busy_cnt = 0, done_cnt = 0, done_cyc = -1, first_busy = -1, overlap = 0;
    int   wcyc [$];
    int   wadr [$];
    int   wdat [$];

    // Cycle index and spec-defined parity (0 in the first cycle after reset).
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        par_m <= rst ? 1'b0 : ~par_m;
        bus.cpu_mem_data <= mem[bus.cpu_mem_addr];
    end

    always @(negedge clk) begin
        if (bus.dma_busy === 1'b1) begin
            busy_cnt++;
            if (first_busy < 0) first_busy = cyc;
        end
        if (bus.dma_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (bus.dma_busy === 1'b1) overlap++;
        end
        if (bus.spram_write_en === 1'b1) begin
            spram[bus.spram_write_addr] = bus.spram_write_data;
            wcyc.push_back(cyc);
            wadr.push_back(int'(bus.spram_write_addr));
            wdat.push_back(int'(bus.spram_write_data));
        end
    end

    // odd: 1 = ALIGN expected, 0 = no ALIGN, -1 = start in the current cycle.
    task automatic launch(input int page, input int base, input int odd, output int s, output int a);
        if (odd >= 0) begin
            for (int t = 0; t < 4; t++) begin
                @(posedge clk); #1;
                if (int'(par_m) == 1 - odd) break;
            end
        end
        busy_cnt = 0; done_cnt = 0; done_cyc = -1; first_busy = -1; overlap = 0;
        wcyc.delete(); wadr.delete(); wdat.delete();
        for (int i = 0; i < 256; i++) spram_snap[i] = spram[i];
        bus.dma_page  = 8'(page);
        bus.oam_addr  = 8'(base);
        bus.dma_start = 1'b1;
        s = cyc;
        a = par_m ? 0 : 1;
        @(posedge clk); #1;
        bus.dma_start = 1'b0;
        bus.dma_page  = 8'($urandom);
        bus.oam_addr  = 8'($urandom);
    endtask

    task automatic wait_done(input int tail, output bit to);
        to = 1'b1;
        for (int t = 0; t < 1200; t++) begin
            @(posedge clk); #1;
            if (done_cnt > 0) begin to = 1'b0; break; end
        end
        repeat (tail) begin @(posedge clk); #1; end
    endtask

    // Reference model: byte k of the page goes to (base+k) mod 256, written 2k cycles after the first.
    task automatic measure(input int s, input int a, input int page, input int base, input int n,
                           output int bad_w, output int bad_sp);
        logic [7:0] expv [256];
        int ea, ed, ec;
        bad_w = 0; bad_sp = 0;
        for (int i = 0; i < 256; i++) expv[i] = spram_snap[i];
        for (int k = 0; k < n; k++) begin
            ea = (base + k) % 256;
            ed = int'(mem[page * 256 + k]);
            ec = s + 3 + a + 2 * k;
            expv[ea] = 8'(ed);
            if (k >= wcyc.size()) bad_w++;
            else if (wcyc[k] != ec || wadr[k] != ea || wdat[k] != ed) bad_w++;
        end
        if (wcyc.size() != n) bad_w++;
        for (int i = 0; i < 256; i++) if (spram[i] !== expv[i]) bad_sp++;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.dma_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({bus.cpu_mem_addr, bus.spram_write_addr, bus.spram_write_data} !== 32'h0) begin errors++; $display("FAIL reset_regs: got %h want 00000000", {bus.cpu_mem_addr, bus.spram_write_addr, bus.spram_write_data}); end
        checks++; if ({bus.spram_write_en, bus.dma_busy, bus.dma_done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {bus.spram_write_en, bus.dma_busy, bus.dma_done}); end
        @(posedge clk); #1;
        bus.dma_page = 8'h02; bus.oam_addr = 8'h00; bus.dma_start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.dma_start = 1'b0;
        busy_cnt = 0; wcyc.delete(); wadr.delete(); wdat.delete();
        repeat (8) begin @(posedge clk); #1; end
        checks++; if (busy_cnt != 0 || wcyc.size() != 0) begin errors++; $display("FAIL start_with_rst: busy %0d writes %0d want 0 0", busy_cnt, wcyc.size()); end
    endtask

    task automatic test_even();
        int s, a, bw, bs, bad; bit to;
        launch(2, 0, 0, s, a);
        wait_done(4, to);
        measure(s, a, 2, 0, 256, bw, bs);
        bad = 0;
        for (int i = 0; i < 256; i++) if (spram[i] !== 8'(i ^ 8'hA5)) bad++;
        checks++; if (to) begin errors++; $display("FAIL even_timeout: no dma_done"); end
        checks++; if (busy_cnt != 513) begin errors++; $display("FAIL even_busy: got %0d want 513", busy_cnt); end
        checks++; if (first_busy != s + 1) begin errors++; $display("FAIL even_busy_rise: got %0d want %0d", first_busy, s + 1); end
        checks++; if (wcyc.size() != 256) begin errors++; $display("FAIL even_wr_count: got %0d want 256", wcyc.size()); end
        checks++; if (done_cnt != 1 || done_cyc != s + 514) begin errors++; $display("FAIL even_done: got %0d@%0d want 1@%0d", done_cnt, done_cyc, s + 514); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL even_done_busy: got %0d want 0", overlap); end
        checks++; if (bw != 0) begin errors++; $display("FAIL even_writes: got %0d bad want 0", bw); end
        checks++; if (bad != 0 || bs != 0) begin errors++; $display("FAIL even_spram: got %0d/%0d bad want 0", bad, bs); end
    endtask

    task automatic test_odd();
        int s, a, bw, bs; bit to;
        for (int i = 0; i < 256; i++) spram[i] = 8'h00;
        launch(2, 0, 1, s, a);
        wait_done(4, to);
        measure(s, a, 2, 0, 256, bw, bs);
        checks++; if (busy_cnt != 514 || to) begin errors++; $display("FAIL odd_busy: got %0d want 514", busy_cnt); end
        checks++; if (done_cnt != 1 || done_cyc != s + 515) begin errors++; $display("FAIL odd_done: got %0d@%0d want 1@%0d", done_cnt, done_cyc, s + 515); end
        checks++; if (bw != 0 || bs != 0) begin errors++; $display("FAIL odd_data: got %0d/%0d bad want 0", bw, bs); end
    endtask

    task automatic test_wrap();
        int s, a, bw, bs; bit to;
        launch(2, 8'hFC, -1, s, a);
        wait_done(4, to);
        measure(s, a, 2, 8'hFC, 256, bw, bs);
        checks++; if (spram[8'hFC] !== mem[16'h0200]) begin errors++; $display("FAIL wrap_fc: got %h want %h", spram[8'hFC], mem[16'h0200]); end
        checks++; if (spram[8'h00] !== mem[16'h0204]) begin errors++; $display("FAIL wrap_00: got %h want %h", spram[8'h00], mem[16'h0204]); end
        checks++; if (spram[8'hFB] !== mem[16'h02FF]) begin errors++; $display("FAIL wrap_fb: got %h want %h", spram[8'hFB], mem[16'h02FF]); end
        checks++; if (bw != 0 || bs != 0 || to) begin errors++; $display("FAIL wrap_data: got %0d/%0d bad want 0", bw, bs); end
    endtask

    task automatic test_start_busy();
        int s, a, bw, bs; bit to;
        launch(2, 8'h40, -1, s, a);
        for (int t = 0; t < 300 && wcyc.size() < 50; t++) begin @(posedge clk); #1; end
        bus.dma_page = 8'h03; bus.oam_addr = 8'h00; bus.dma_start = 1'b1;
        @(posedge clk); #1;
        bus.dma_start = 1'b0;
        wait_done(6, to);
        measure(s, a, 2, 8'h40, 256, bw, bs);
        checks++; if (done_cnt != 1 || to) begin errors++; $display("FAIL busy_start_done: got %0d want 1", done_cnt); end
        checks++; if (busy_cnt != 513 + a) begin errors++; $display("FAIL busy_start_len: got %0d want %0d", busy_cnt, 513 + a); end
        checks++; if (bw != 0 || bs != 0) begin errors++; $display("FAIL busy_start_data: got %0d/%0d bad want 0", bw, bs); end
    endtask

    task automatic test_reset_mid();
        int s, a, bw, bs; bit to;
        for (int i = 0; i < 256; i++) spram[i] = 8'($urandom);
        launch(2, 0, -1, s, a);
        for (int t = 0; t < 400 && wcyc.size() < 100; t++) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({bus.spram_write_en, bus.dma_busy, bus.dma_done} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags: got %b want 000", {bus.spram_write_en, bus.dma_busy, bus.dma_done}); end
        checks++; if (bus.cpu_mem_addr !== 16'h0000 || bus.spram_write_addr !== 8'h00) begin errors++; $display("FAIL rst_mid_addr: got %h/%h want 0000/00", bus.cpu_mem_addr, bus.spram_write_addr); end
        repeat (10) begin @(posedge clk); #1; end
        measure(s, a, 2, 0, 100, bw, bs);
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL rst_mid_done: got %0d want 0", done_cnt); end
        checks++; if (bw != 0 || bs != 0) begin errors++; $display("FAIL rst_mid_spram: got %0d/%0d bad want 0", bw, bs); end
        launch(3, 8'h10, -1, s, a);
        wait_done(4, to);
        measure(s, a, 3, 8'h10, 256, bw, bs);
        checks++; if (to || busy_cnt != 513 + a || bw != 0 || bs != 0) begin errors++; $display("FAIL rst_mid_restart: busy %0d want %0d, bad %0d/%0d", busy_cnt, 513 + a, bw, bs); end
    endtask

    task automatic test_back_to_back();
        int s, a, bw, bs; bit to;
        launch(2, 8'h20, -1, s, a);
        wait_done(0, to);
        measure(s, a, 2, 8'h20, 256, bw, bs);
        checks++; if (to || bw != 0 || bs != 0) begin errors++; $display("FAIL b2b_first: bad %0d/%0d want 0", bw, bs); end
        launch(3, 8'h80, -1, s, a);
        wait_done(4, to);
        measure(s, a, 3, 8'h80, 256, bw, bs);
        checks++; if (first_busy != s + 1) begin errors++; $display("FAIL b2b_accept: got %0d want %0d", first_busy, s + 1); end
        checks++; if (to || busy_cnt != 513 + a || done_cnt != 1 || bw != 0 || bs != 0) begin errors++; $display("FAIL b2b_second: busy %0d want %0d, done %0d, bad %0d/%0d", busy_cnt, 513 + a, done_cnt, bw, bs); end
    endtask

    task automatic test_sprite_page();
        int s, a, bad; bit to;
        for (int i = 0; i < 256; i++) mem[16'h0500 + i] = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            mem[16'h0500 + 4 * i]     = 8'h00;
            mem[16'h0500 + 4 * i + 1] = 8'(i);
            mem[16'h0500 + 4 * i + 2] = 8'h1F;
            mem[16'h0500 + 4 * i + 3] = 8'(8 * i);
        end
        launch(5, 0, -1, s, a);
        wait_done(4, to);
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (spram[4 * i] !== 8'h00 || spram[4 * i + 1] !== 8'(i) || spram[4 * i + 2] !== 8'h1F || spram[4 * i + 3] !== 8'(8 * i)) bad++;
        checks++; if (to || bad != 0) begin errors++; $display("FAIL sprite_table: got %0d bad sprites want 0", bad); end
    endtask

    task automatic test_random();
        int s, a, bw, bs, pg, bs0, od; bit to;
        for (int r = 0; r < 5; r++) begin
            pg = int'($urandom_range(255)); bs0 = int'($urandom_range(255)); od = int'($urandom_range(1));
            launch(pg, bs0, od, s, a);
            wait_done(3, to);
            measure(s, a, pg, bs0, 256, bw, bs);
            checks++; if (to || busy_cnt != 513 + od || done_cnt != 1) begin errors++; $display("FAIL rand_timing[%0d]: busy %0d want %0d, done %0d", r, busy_cnt, 513 + od, done_cnt); end
            checks++; if (bw != 0 || bs != 0) begin errors++; $display("FAIL rand_data[%0d]: bad %0d/%0d want 0", r, bw, bs); end
        end
    endtask

    initial begin
        bus.dma_start = 1'b0; bus.dma_page = 8'h00; bus.oam_addr = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + i] = 8'(i ^ 8'hA5);
            mem[16'h0300 + i] = ~8'(i ^ 8'hA5);
            spram[i] = 8'h00;
        end
        test_reset();
        test_even();
        test_odd();
        test_wrap();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        test_sprite_page();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
